lsu_mem_initiator: RTL and testbench
====================================

// Module: lsu_mem_initiator
// PURPOSE
//  CPU-side initiator for the data-memory port (DMWr/DMCtrl/Address/DataWr/DataRd).
//  Accepts load/store requests from the pipeline, drives the memory port, returns load data.
//  Aligned accesses are issued as one native beat. Misaligned half/word accesses are split
//  into byte beats, and read bytes are reassembled and sign/zero-extended locally.
// PARAMETERS
//  SPLIT_MISALIGNED  1  1: split misaligned accesses into byte beats; 0: flag them as error
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   reset, asynchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept a request (high only in IDLE)
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   000 b, 001 h, 010 w, 100 bu, 101 hu
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, little-endian, low bytes used for b/h
//  rsp_valid   out  1   one-cycle response pulse; no back-pressure
//  rsp_rdata   out  32  extended load data; 0 for stores and errors
//  rsp_err     out  1   request illegal or misaligned-rejected; valid with rsp_valid
//  DMWr        out  1   memory write enable
//  DMCtrl      out  3   memory access size/sign code
//  Address     out  32  memory byte address
//  DataWr      out  32  memory write data
//  DataRd      in   32  memory read data, combinational from Address/DMCtrl
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; DMWr=0; DMCtrl=000;
//   Address=0; DataWr=0. While rst is high, DMWr is held 0 asynchronously.
//  All memory-port outputs are decoded from registers only, so DMWr is glitch-free.
//  When no beat is active: DMWr=0, DMCtrl=000, Address=0, DataWr=0.
//  FSM states: IDLE, ACCESS, SPLIT, RESP.
//  IDLE: on req_valid&&req_ready, register we/funct3/addr/wdata, then decode.
//   Illegal request (funct3 011/110/111, or store with 100/101) -> RESP, err=1, no beat.
//   Misaligned request (h with addr[0]=1, w with addr[1:0]!=0):
//    SPLIT_MISALIGNED=1 -> SPLIT; SPLIT_MISALIGNED=0 -> RESP, err=1, no beat.
//   Any other request -> ACCESS.
//  ACCESS: one cycle. DMCtrl=funct3, Address=addr, DataWr=wdata, DMWr=we.
//   Load data is captured from DataRd at the end of the cycle. Next state is RESP.
//  SPLIT: N beats, N=2 (h/hu) or 4 (w), beat counter k=0..N-1, one beat per cycle.
//   Each beat: DMCtrl=000, Address=addr+k (mod 2^32, wraps), DMWr=we, DataWr={24'b0, wdata[8k+:8]}.
//   Loads capture DataRd[7:0] into assembly byte k.
//   After beat N-1 the assembled value is extended by funct3 (001 sign from byte 1, 101 zero,
//   010 none) and the state goes to RESP.
//  RESP: one cycle with rsp_valid=1 and rsp_rdata/rsp_err driven; req_ready=0; then IDLE.
//   rsp_err and rsp_rdata return to 0 in IDLE.
//  Latency from the accept edge to rsp_valid high:
//   2 cycles for aligned accesses, N+1 cycles for split accesses, 1 cycle for errors.
//  A request held valid while req_ready=0 is not sampled. Back-to-back throughput is one
//   request per (latency+1) cycles.
//  Reset mid-operation aborts immediately, with no response. A split store may be left
//   partially written; this is accepted behaviour.
//  A store's response has rsp_rdata=0 and rsp_err=0.
// TESTING
//  1 Store w 0x100 data 0xDEADBEEF, then load w 0x100 -> store: DMWr=1 for exactly 1 cycle with
//    DMCtrl=010; load: rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after the accept edge.
//  2 Store w 0x101 data 0x11223344 -> 4 beats at addr 0x101..0x104 with data 44,33,22,11,
//    DMCtrl=000; load w 0x101 -> 0x11223344, rsp_valid at +5.
//  3 Memory 0x203=0x01, 0x204=0x80: load h 0x203 -> 0xFFFF8001; load hu 0x203 -> 0x00008001.
//  4 funct3=011 load, and store with funct3=100 -> DMWr never 1, rsp_err=1, rsp_rdata=0, rsp at +1;
//    with SPLIT_MISALIGNED=0, load w 0x102 -> rsp_err=1 and no beat.
//  5 rst raised during beat 2 of a split store at 0x301 -> DMWr=0 in the same cycle, no rsp_valid,
//    req_ready=1 after release, bytes 0x301..0x302 written and 0x303..0x304 untouched.
//  6 Store h 0xFFFFFFFF data 0xABCD -> beat Address 0xFFFFFFFF data CD, then 0x00000000 data AB.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the data-memory port: aligned accesses go out as one native beat,
// misaligned half/word accesses are split into byte beats and reassembled locally.
module lsu_mem_initiator #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    output logic [31:0] Address,
    output logic [31:0] DataWr,
    input  logic [31:0] DataRd
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t          state, state_n;
    logic            we_q, we_n;
    logic [2:0]      f3_q, f3_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [DW-1:0]   wdata_q, wdata_n;
    logic [DW-1:0]   asm_q, asm_n;
    logic            err_q, err_n;
    logic [1:0]      k_q, k_n;
    logic [1:0]      last_k;
    logic            illegal, misaligned;

    logic            ready_n, rsp_valid_n, rsp_err_n, dmwr_n;
    logic [DW-1:0]   rsp_rdata_n, datawr_n;
    logic [2:0]      dmctrl_n;
    logic [AW-1:0]   address_n;

    // Sign/zero extension of a locally assembled value by access size.
    function automatic logic [DW-1:0] extend(input logic [DW-1:0] v, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{v[7]}}, v[7:0]};
            3'b100:  extend = {24'b0, v[7:0]};
            3'b001:  extend = {{16{v[15]}}, v[15:0]};
            3'b101:  extend = {16'b0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    assign illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    assign last_k = f3_q[1] ? 2'd3 : 2'd1;

    // Next state, request capture, load assembly and next registered outputs.
    always_comb begin
        state_n     = state;
        we_n        = we_q;
        f3_n        = f3_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        asm_n       = asm_q;
        err_n       = err_q;
        k_n         = k_q;
        ready_n     = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
        dmwr_n      = 1'b0;
        dmctrl_n    = 3'b000;
        address_n   = '0;
        datawr_n    = '0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_n    = req_we;
                    f3_n    = req_funct3;
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    asm_n   = '0;
                    k_n     = 2'd0;
                    err_n   = 1'b0;
                    if (illegal) begin
                        state_n = RESP;
                        err_n   = 1'b1;
                    end else if (misaligned) begin
                        if (SPLIT_MISALIGNED) begin
                            state_n = SPLIT;
                        end else begin
                            state_n = RESP;
                            err_n   = 1'b1;
                        end
                    end else begin
                        state_n = ACCESS;
                    end
                end
            end
            ACCESS: begin
                asm_n   = DataRd;
                state_n = RESP;
            end
            SPLIT: begin
                asm_n[{k_q, 3'b000} +: 8] = DataRd[7:0];
                if (k_q == last_k) begin
                    state_n = RESP;
                end else begin
                    k_n = k_q + 2'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the upcoming state so every port pin comes straight from a flop.
        ready_n = (state_n == IDLE);
        case (state_n)
            ACCESS: begin
                dmwr_n    = we_n;
                dmctrl_n  = f3_n;
                address_n = addr_n;
                datawr_n  = wdata_n;
            end
            SPLIT: begin
                dmwr_n    = we_n;
                address_n = addr_n + AW'(k_n);
                datawr_n  = {24'b0, wdata_n[{k_n, 3'b000} +: 8]};
            end
            RESP: begin
                rsp_valid_n = 1'b1;
                rsp_err_n   = err_n;
                rsp_rdata_n = (err_n || we_n) ? '0 : extend(asm_n, f3_n);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            asm_q     <= '0;
            err_q     <= 1'b0;
            k_q       <= 2'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            DMWr      <= 1'b0;
            DMCtrl    <= 3'b000;
            Address   <= '0;
            DataWr    <= '0;
        end else begin
            state     <= state_n;
            we_q      <= we_n;
            f3_q      <= f3_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            asm_q     <= asm_n;
            err_q     <= err_n;
            k_q       <= k_n;
            req_ready <= ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
            DMWr      <= dmwr_n;
            DMCtrl    <= dmctrl_n;
            Address   <= address_n;
            DataWr    <= datawr_n;
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: byte-addressed memory model, response scoreboard,
// beat log, and a second instance with misaligned splitting disabled.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, DMWr;
    logic [31:0] rsp_rdata, Address, DataWr, DataRd;
    logic [2:0]  DMCtrl;

    logic        q2_valid = 1'b0, q2_we = 1'b0;
    logic [2:0]  q2_funct3 = 3'b000;
    logic [31:0] q2_addr = '0, q2_wdata = '0;
    logic        q2_ready, q2_rsp_valid, q2_rsp_err, q2_dmwr;
    logic [31:0] q2_rsp_rdata, q2_address, q2_datawr;
    logic [31:0] q2_datard = '0;
    logic [2:0]  q2_dmctrl;

    lsu_mem_initiator #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .DMWr(DMWr), .DMCtrl(DMCtrl), .Address(Address), .DataWr(DataWr), .DataRd(DataRd)
    );

    lsu_mem_initiator #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst), .req_valid(q2_valid), .req_ready(q2_ready), .req_we(q2_we),
        .req_funct3(q2_funct3), .req_addr(q2_addr), .req_wdata(q2_wdata),
        .rsp_valid(q2_rsp_valid), .rsp_rdata(q2_rsp_rdata), .rsp_err(q2_rsp_err),
        .DMWr(q2_dmwr), .DMCtrl(q2_dmctrl), .Address(q2_address), .DataWr(q2_datawr),
        .DataRd(q2_datard)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int active_cnt = 0;
    int active2 = 0;
    logic [32:0] exp_q[$];
    logic [31:0] bq_addr[$];
    logic [31:0] bq_data[$];
    logic [2:0]  bq_ctrl[$];

    // Little-endian byte memory; reads extend per DMCtrl like the real data memory.
    logic [7:0] mem [0:1023] = '{default: 8'h00};
    logic [9:0] ra;
    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        ra = Address[9:0];
        b0 = mem[ra];
        b1 = mem[ra + 10'd1];
        b2 = mem[ra + 10'd2];
        b3 = mem[ra + 10'd3];
        case (DMCtrl)
            3'b000:  DataRd = {{24{b0[7]}}, b0};
            3'b100:  DataRd = {24'b0, b0};
            3'b001:  DataRd = {{16{b1[7]}}, b1, b0};
            3'b101:  DataRd = {16'b0, b1, b0};
            3'b010:  DataRd = {b3, b2, b1, b0};
            default: DataRd = '0;
        endcase
    end

    always @(posedge clk) begin
        if (DMWr) begin
            mem[Address[9:0]] <= DataWr[7:0];
            if (DMCtrl[1:0] != 2'b00) mem[Address[9:0] + 10'd1] <= DataWr[15:8];
            if (DMCtrl[1:0] == 2'b10) begin
                mem[Address[9:0] + 10'd2] <= DataWr[23:16];
                mem[Address[9:0] + 10'd3] <= DataWr[31:24];
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (DMWr) begin
            bq_addr.push_back(Address);
            bq_data.push_back(DataWr);
            bq_ctrl.push_back(DMCtrl);
        end
        if (DMWr || DMCtrl != 3'b000 || Address != 32'h0) active_cnt <= active_cnt + 1;
        if (q2_dmwr || q2_dmctrl != 3'b000 || q2_address != 32'h0) active2 <= active2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, score the response against the queued expectation and its latency.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] er, input logic ee,
                          input int elat);
        int n;
        int acc;
        logic [32:0] e;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        exp_q.push_back({ee, er});
        @(posedge clk); #1; acc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", 32'(rsp_err), 32'(e[32]));
        chk("latency", 32'(cyc - acc + 1), 32'(elat));
        @(negedge clk);
        chk("rsp_pulse_len", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int b;
        int a;
        int acc;
        int n;
        logic seen;
        logic [7:0] exp_bytes [4];

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_dmwr", 32'(DMWr), 32'd0);
        chk("reset_dmctrl", 32'(DMCtrl), 32'd0);
        chk("reset_address", Address, 32'd0);
        chk("reset_datawr", DataWr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned word store then load.
        b = bq_addr.size();
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        chk("w_store_beats", 32'(bq_addr.size() - b), 32'd1);
        chk("w_store_ctrl", 32'(bq_ctrl[b]), 32'h2);
        chk("w_store_addr", bq_addr[b], 32'h100);
        chk("w_store_data", bq_data[b], 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // Misaligned word store split into four byte beats, then reassembled load.
        exp_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};
        b = bq_addr.size();
        do_req(1'b1, 3'b010, 32'h101, 32'h11223344, 32'h0, 1'b0, 5);
        chk("split_w_beats", 32'(bq_addr.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("split_w_addr", bq_addr[b + i], 32'h101 + 32'(i));
            chk("split_w_data", bq_data[b + i], {24'h0, exp_bytes[i]});
            chk("split_w_ctrl", 32'(bq_ctrl[b + i]), 32'd0);
        end
        do_req(1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 1'b0, 5);

        // Misaligned half loads with sign/zero extension, plus aligned byte loads.
        do_req(1'b1, 3'b000, 32'h203, 32'h01, 32'h0, 1'b0, 2);
        do_req(1'b1, 3'b000, 32'h204, 32'h80, 32'h0, 1'b0, 2);
        do_req(1'b0, 3'b001, 32'h203, 32'h0, 32'hFFFF8001, 1'b0, 3);
        do_req(1'b0, 3'b101, 32'h203, 32'h0, 32'h00008001, 1'b0, 3);
        do_req(1'b0, 3'b000, 32'h204, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        do_req(1'b0, 3'b100, 32'h204, 32'h0, 32'h00000080, 1'b0, 2);

        // Illegal requests respond with an error and never touch the port.
        a = active_cnt;
        b = bq_addr.size();
        do_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
        do_req(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 1'b1, 1);
        do_req(1'b1, 3'b110, 32'h100, 32'h55, 32'h0, 1'b1, 1);
        chk("illegal_no_activity", 32'(active_cnt - a), 32'd0);
        chk("illegal_no_write", 32'(bq_addr.size() - b), 32'd0);

        // Non-splitting instance rejects a misaligned word load.
        a = active2;
        q2_valid = 1'b1; q2_we = 1'b0; q2_funct3 = 3'b010; q2_addr = 32'h102;
        @(posedge clk); #1; acc = cyc;
        @(negedge clk);
        q2_valid = 1'b0;
        n = 0;
        while (!q2_rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("nosplit_rsp_valid", 32'(q2_rsp_valid), 32'd1);
        chk("nosplit_rsp_err", 32'(q2_rsp_err), 32'd1);
        chk("nosplit_rsp_rdata", q2_rsp_rdata, 32'd0);
        chk("nosplit_latency", 32'(cyc - acc + 1), 32'd1);
        @(negedge clk);
        chk("nosplit_no_beat", 32'(active2 - a), 32'd0);

        // Reset during the third beat of a split store aborts it with no response.
        do_req(1'b1, 3'b010, 32'h300, 32'hAAAAAAAA, 32'h0, 1'b0, 2);
        do_req(1'b1, 3'b010, 32'h304, 32'hAAAAAAAA, 32'h0, 1'b0, 2);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h301; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_beat2_active", 32'(DMWr), 32'd1);
        chk("abort_beat2_addr", Address, 32'h303);
        rst = 1'b1;
        #1;
        chk("abort_dmwr_async", 32'(DMWr), 32'd0);
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen = seen | rsp_valid; end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); seen = seen | rsp_valid; end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_301", 32'(mem[10'h301]), 32'h44);
        chk("abort_mem_302", 32'(mem[10'h302]), 32'h33);
        chk("abort_mem_303", 32'(mem[10'h303]), 32'hAA);
        chk("abort_mem_304", 32'(mem[10'h304]), 32'hAA);

        // Split half store wrapping the top of the address space.
        b = bq_addr.size();
        do_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 32'h0, 1'b0, 3);
        chk("wrap_beats", 32'(bq_addr.size() - b), 32'd2);
        chk("wrap_addr0", bq_addr[b], 32'hFFFFFFFF);
        chk("wrap_data0", bq_data[b], 32'h000000CD);
        chk("wrap_addr1", bq_addr[b + 1], 32'h00000000);
        chk("wrap_data1", bq_data[b + 1], 32'h000000AB);
        chk("wrap_ctrl", 32'(bq_ctrl[b + 1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
